swizzle_c2d_sched: RTL and testbench

//  Round-robin scheduler sharing one CRAM-to-DRAM swizzle among NUM_REQ compute-RAM banks.

---
 rtl/swizzle_c2d_sched_if.sv | 32 +++
 rtl/swizzle_c2d_sched.sv | 163 ++++++++++++++++
 tb/tb_swizzle_c2d_sched.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/swizzle_c2d_sched_if.sv
// rtl/swizzle_c2d_sched_if.sv - bank request, CRAM read and swizzle stream signals of the scheduler
interface swizzle_c2d_sched_if #(
    parameter int NUM_REQ    = 4,
    parameter int RAM_DWIDTH = 40,
    parameter int RAM_AWIDTH = 9,
    parameter int MEM_AWIDTH = 9
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*MEM_AWIDTH-1:0] base_addr;
    logic                          mem_ready;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic                          cram_rd_en;
    logic [RAM_AWIDTH-1:0]         cram_rd_addr;
    logic [RAM_DWIDTH-1:0]         cram_rd_data;
    logic                          sw_data_valid;
    logic [RAM_DWIDTH-1:0]         sw_data_in;
    logic                          sw_data_last;
    logic [MEM_AWIDTH-1:0]         sw_addr_start;

    modport master (
        input  req, base_addr, mem_ready, cram_rd_data,
        output grant, done, cram_rd_en, cram_rd_addr,
        output sw_data_valid, sw_data_in, sw_data_last, sw_addr_start
    );

    modport slave (
        output req, base_addr, mem_ready, cram_rd_data,
        input  grant, done, cram_rd_en, cram_rd_addr,
        input  sw_data_valid, sw_data_in, sw_data_last, sw_addr_start
    );
endinterface

// File: rtl/swizzle_c2d_sched.sv
// rtl/swizzle_c2d_sched.sv - round-robin scheduler streaming CRAM banks into one swizzle
// One bank owns the swizzle per transfer; words leave one cycle after their CRAM read strobe.
module swizzle_c2d_sched #(
    parameter int NUM_REQ      = 4,
    parameter int RAM_DWIDTH   = 40,
    parameter int RAM_AWIDTH   = 9,
    parameter int MEM_AWIDTH   = 9,
    parameter int XFER_WORDS   = 80,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                clk,
    input  logic                resetn,
    swizzle_c2d_sched_if.master bus
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(XFER_WORDS + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           owner_q, owner_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic [RAM_AWIDTH-1:0]   addr_q, addr_d;
    logic [MEM_AWIDTH-1:0]   start_q, start_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;

    logic                    rd_en;
    logic                    final_rd;
    logic                    pick_found;
    logic [PW-1:0]           pick_idx;
    logic [MEM_AWIDTH-1:0]   pick_base;

    // Search starts one past the last owner so a re-raised request waits behind the others.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!pick_found && bus.req[j] && (j == (int'(ptr_q) + k) % NUM_REQ)) begin
                    pick_found = 1'b1;
                    pick_idx   = PW'(j);
                end
            end
        end
    end

    always_comb begin
        pick_base = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick_idx == PW'(j)) begin
                pick_base = bus.base_addr[j*MEM_AWIDTH +: MEM_AWIDTH];
            end
        end
    end

    assign rd_en    = (state_q == S_STREAM) && bus.mem_ready && (cnt_q < CW'(XFER_WORDS));
    assign final_rd = rd_en && (cnt_q == CW'(XFER_WORDS - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        addr_d  = addr_q;
        start_d = start_q;
        valid_d = rd_en;
        last_d  = final_rd;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                    start_d = pick_base;
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (rd_en) begin
                    addr_d = addr_q + RAM_AWIDTH'(1);
                    cnt_d  = cnt_q + CW'(1);
                end
                if (final_rd) begin
                    drain_d = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // The final word is still on sw_data_* during the first drain cycle.
                if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                    done_d  = grant_q;
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_DONE: begin
                ptr_d   = owner_q;
                grant_d = '0;
                start_d = '0;
                addr_d  = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            ptr_q   <= PW'(NUM_REQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            addr_q  <= '0;
            start_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            addr_q  <= addr_d;
            start_q <= start_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.done          = done_q;
    assign bus.cram_rd_en    = rd_en;
    assign bus.cram_rd_addr  = addr_q;
    assign bus.sw_data_valid = valid_q;
    assign bus.sw_data_in    = bus.cram_rd_data;
    assign bus.sw_data_last  = last_q;
    assign bus.sw_addr_start = start_q;
endmodule

// File: tb/tb_swizzle_c2d_sched.sv
// tb/tb_swizzle_c2d_sched.sv - scoreboard bench for swizzle_c2d_sched with a round-robin reference model
module tb_swizzle_c2d_sched;
    localparam int N   = 4;
    localparam int DWD = 40;
    localparam int AW  = 9;
    localparam int MAW = 9;
    localparam int XW  = 80;
    localparam int DR  = 4;

    typedef struct {
        int              bank;
        logic [DWD-1:0]  data;
        logic            last;
        logic [MAW-1:0]  start;
    } word_t;

    logic clk;
    logic resetn;
    logic [N-1:0] req_r;
    int   rdy_mode;
    int   n_checks;
    int   n_pass;
    int   word_cnt;
    int   cyc;
    int   last_cyc;
    int   model_ptr;
    word_t exp_q[$];
    int    exp_done[$];

    swizzle_c2d_sched_if #(.NUM_REQ(N), .RAM_DWIDTH(DWD), .RAM_AWIDTH(AW), .MEM_AWIDTH(MAW)) bus ();

    swizzle_c2d_sched #(
        .NUM_REQ(N), .RAM_DWIDTH(DWD), .RAM_AWIDTH(AW), .MEM_AWIDTH(MAW),
        .XFER_WORDS(XW), .DRAIN_CYCLES(DR)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    assign bus.req = req_r;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DWD-1:0] mk(input int b, input int a);
        logic [15:0] mix;
        mix = 16'hC3A5 ^ 16'(a * 7);
        return {8'(b), 16'(a), mix};
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // CRAM banks: one-cycle read latency, content encodes bank and address
    always @(posedge clk) begin
        if (bus.cram_rd_en) bus.cram_rd_data <= mk(oh_idx(bus.grant), int'(bus.cram_rd_addr));
    end

    initial begin
        bus.mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus.mem_ready = ~bus.mem_ready;
                2:       bus.mem_ready = 1'($urandom_range(0, 1));
                default: bus.mem_ready = 1'b1;
            endcase
        end
    end

    // Reference: each requester holds req until its done, so a mask is served in rotational order.
    task automatic serve(input logic [N-1:0] mask);
        int    last_b;
        word_t w;
        last_b = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (model_ptr + k) % N;
            if (mask[i]) begin
                for (int a = 0; a < XW; a++) begin
                    w.bank  = i;
                    w.data  = mk(i, a % (1 << AW));
                    w.last  = (a == XW - 1);
                    w.start = bus.base_addr[i*MAW +: MAW];
                    exp_q.push_back(w);
                end
                exp_done.push_back(i);
                last_b = i;
            end
        end
        if (last_b >= 0) model_ptr = last_b;
    endtask

    task automatic check_outputs_zero(input string nm);
        chk(nm, {bus.grant, bus.done, bus.cram_rd_en, bus.cram_rd_addr,
                 bus.sw_data_valid, bus.sw_data_last, bus.sw_addr_start}, 64'd0);
    endtask

    task automatic do_reset();
        req_r  = '0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        exp_q.delete();
        exp_done.delete();
        model_ptr = N - 1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic wait_idle(input int limit);
        for (int c = 0; c < limit && req_r != 0; c++) @(posedge clk);
        chk("phase_complete", 64'(req_r), 64'd0);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_words(input int target);
        for (int c = 0; c < 1000 && word_cnt < target; c++) @(posedge clk);
        chk("words_reached", 64'(word_cnt >= target), 64'd1);
    endtask

    task automatic run_phase(input logic [N-1:0] mask);
        @(posedge clk);
        #1;
        serve(mask);
        req_r = req_r | mask;
        wait_idle(600 * N);
    endtask

    task automatic rand_base();
        for (int i = 0; i < N; i++) bus.base_addr[i*MAW +: MAW] = MAW'($urandom);
    endtask

    // Monitor: scoreboard compare, done timing, read-address stepping
    initial begin
        logic            have_prev;
        logic [N-1:0]    prev_grant;
        logic            prev_en;
        logic [AW-1:0]   prev_addr;
        word_t           w;
        have_prev = 1'b0;
        prev_grant = '0;
        prev_en = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetn) begin
                have_prev = 1'b0;
                continue;
            end
            if (bus.grant != 0) chk("grant_onehot", 64'($countones(bus.grant)), 64'd1);
            if (bus.cram_rd_en) chk("rd_en_needs_ready", 64'(bus.mem_ready), 64'd1);
            if (have_prev && bus.grant != 0 && bus.grant == prev_grant) begin
                chk("rd_addr_step", 64'(bus.cram_rd_addr),
                    64'(prev_en ? prev_addr + AW'(1) : prev_addr));
            end
            if (bus.sw_data_valid) begin
                word_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(bus.sw_data_in), 64'd0);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_data", 64'(bus.sw_data_in), 64'(w.data));
                    chk("word_last", 64'(bus.sw_data_last), 64'(w.last));
                    chk("word_grant", 64'(bus.grant), 64'(1 << w.bank));
                    chk("word_addr_start", 64'(bus.sw_addr_start), 64'(w.start));
                    if (w.last) last_cyc = cyc;
                end
            end
            if (bus.done != 0) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    int b;
                    b = exp_done.pop_front();
                    chk("done_bank", 64'(bus.done), 64'(1 << b));
                    chk("done_drain_gap", 64'(cyc - last_cyc), 64'(DR));
                end
                req_r = req_r & ~bus.done;
            end
            have_prev  = 1'b1;
            prev_grant = bus.grant;
            prev_en    = bus.cram_rd_en;
            prev_addr  = bus.cram_rd_addr;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        n_checks = 0;
        n_pass = 0;
        word_cnt = 0;
        cyc = 0;
        last_cyc = 0;
        rdy_mode = 0;
        req_r = '0;
        resetn = 1'b0;
        bus.base_addr = '0;
        rand_base();
        repeat (2) @(posedge clk);
        do_reset();

        repeat (8) begin
            @(posedge clk);
            #1;
            check_outputs_zero("idle_quiet");
        end

        // single bank, contiguous, grant one cycle after request
        @(posedge clk);
        #1;
        serve(4'b0001);
        req_r = 4'b0001;
        @(posedge clk);
        #1;
        chk("grant_latency", 64'(bus.grant), 64'd1);
        chk("grant_rd_addr", 64'(bus.cram_rd_addr), 64'd0);
        chk("grant_addr_start", 64'(bus.sw_addr_start), 64'(bus.base_addr[0 +: MAW]));
        wait_idle(600);

        // alternation between two requesters
        run_phase(4'b0101);
        run_phase(4'b0101);

        // back-pressure toggling every cycle
        rdy_mode = 1;
        run_phase(4'b0100);
        rdy_mode = 0;

        // fresh pointer, fixed base slices
        do_reset();
        bus.base_addr[0 +: MAW]     = 9'h000;
        bus.base_addr[3*MAW +: MAW] = 9'h100;
        run_phase(4'b1001);

        // reset in the middle of a transfer, then restart
        rand_base();
        @(posedge clk);
        #1;
        start = word_cnt;
        serve(4'b0010);
        req_r = 4'b0010;
        wait_words(start + 37);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        req_r = '0;
        @(posedge clk);
        #1;
        check_outputs_zero("midreset_outputs");
        exp_q.delete();
        exp_done.delete();
        model_ptr = N - 1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        run_phase(4'b0010);

        // owner drops req mid-stream while another bank raises
        @(posedge clk);
        #1;
        start = word_cnt;
        serve(4'b0010);
        req_r = 4'b0010;
        wait_words(start + 20);
        @(posedge clk);
        #1;
        req_r[1] = 1'b0;
        req_r[3] = 1'b1;
        serve(4'b1000);
        wait_idle(1200);

        // randomized masks, bases and back-pressure
        rdy_mode = 2;
        for (int it = 0; it < 6; it++) begin
            rand_base();
            run_phase(N'($urandom_range(1, (1 << N) - 1)));
        end
        rdy_mode = 0;

        repeat (5) @(posedge clk);
        chk("scoreboard_words_empty", 64'(exp_q.size()), 64'd0);
        chk("scoreboard_done_empty", 64'(exp_done.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
